// File: rtl/coin_pkg.sv
// Shared coin encodings and default sizing for the coin acceptor front end.
package coin_pkg;

  typedef enum logic {
    COIN_HALF = 1'b0,
    COIN_ONE  = 1'b1
  } coin_e;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int QDEPTH_DEF     = 4;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, saturating debounce counter and
// rising-edge detect on the filtered level.
module coin_debounce #(
  parameter int DEB_CYCLES = coin_pkg::DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic evt_o
);

  logic       meta_q, s_q, f_q, f_d;
  logic [7:0] cnt_q, cnt_d;
  logic       at_lim;

  assign at_lim = (cnt_q == 8'(DEB_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    f_d   = f_q;
    if (s_q != f_q) begin
      if (at_lim) f_d   = s_q;
      else        cnt_d = cnt_q + 8'd1;
    end
  end

  // The event fires in the cycle whose edge flips f high, so the push lands on that edge.
  assign evt_o = s_q & ~f_q & at_lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
      f_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      s_q    <= meta_q;
      f_q    <= f_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced sensors feed a small coin FIFO that drains one
// d1/d2 pulse per cycle while the vending controller is not holding.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int QDEPTH     = QDEPTH_DEF,
  localparam int PW        = $clog2(QDEPTH),
  localparam int LW        = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_half_raw,
  input  logic          coin_one_raw,
  input  logic          hold,
  output logic          d1,
  output logic          d2,
  output logic          coin_reject,
  output logic [LW-1:0] q_level
);

  logic [1:0] raw, evt;
  assign raw = {coin_one_raw, coin_half_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw_i(raw[ch]),
      .evt_o(evt[ch])
    );
  end

  coin_e         mem_q [QDEPTH];
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d, wp1;
  logic [LW-1:0] level_q, level_d;
  logic [LW:0]   free;
  logic          pop, push_h, push_o, rej_d;
  logic          d1_q, d2_q, rej_q;

  // Pop frees its slot before pushes are judged; half beats one for the last slot.
  always_comb begin
    pop     = !hold && (level_q != '0);
    free    = (LW+1)'(QDEPTH) - (LW+1)'(level_q) + (LW+1)'(pop);
    push_h  = evt[0] && (free != '0);
    push_o  = evt[1] && (free > (LW+1)'(push_h));
    rej_d   = (evt[0] && !push_h) || (evt[1] && !push_o);
    wp1     = wp_q + PW'(push_h);
    wp_d    = wp1 + PW'(push_o);
    rp_d    = rp_q + PW'(pop);
    level_d = level_q - LW'(pop) + LW'(push_h) + LW'(push_o);
  end

  always_ff @(posedge clk) begin
    if (push_h) mem_q[wp_q] <= COIN_HALF;
    if (push_o) mem_q[wp1]  <= COIN_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      level_q <= '0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      level_q <= level_d;
      d1_q    <= pop && (mem_q[rp_q] == COIN_HALF);
      d2_q    <= pop && (mem_q[rp_q] == COIN_ONE);
      rej_q   <= rej_d;
    end
  end

  assign d1          = d1_q;
  assign d2          = d2_q;
  assign coin_reject = rej_q;
  assign q_level     = level_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor at default sizing (DEB_CYCLES=4, QDEPTH=4).
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_half_raw = 1'b0;
  logic       coin_one_raw  = 1'b0;
  logic       hold = 1'b0;
  logic       d1, d2, coin_reject;
  logic [2:0] q_level;

  int n_cmp = 0;
  int n_err = 0;
  int rej_cnt, pulse_cnt;

  coin_acceptor #(.DEB_CYCLES(4), .QDEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_half_raw(coin_half_raw),
    .coin_one_raw (coin_one_raw),
    .hold         (hold),
    .d1           (d1),
    .d2           (d2),
    .coin_reject  (coin_reject),
    .q_level      (q_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One coin on a channel: high for hi cycles, then low for lo cycles.
  task automatic coin(input bit one, input int hi, input int lo);
    if (one) coin_one_raw = 1'b1; else coin_half_raw = 1'b1;
    for (int k = 0; k < hi + lo; k++) begin
      if (k == hi) begin
        coin_one_raw  = 1'b0;
        coin_half_raw = 1'b0;
      end
      tick();
      if (coin_reject) rej_cnt++;
      if (d1 || d2) pulse_cnt++;
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_d1", {7'd0, d1}, 8'd0);
    chk("rst_d2", {7'd0, d2}, 8'd0);
    chk("rst_rej", {7'd0, coin_reject}, 8'd0);
    chk("rst_lvl", {5'd0, q_level}, 8'd0);
    rst = 1'b0;

    // Single half coin: enqueue at E6, d1 at E7
    coin_half_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("half_d1", {7'd0, d1}, (k == 7) ? 8'd1 : 8'd0);
      chk("half_d2", {7'd0, d2}, 8'd0);
      chk("half_lvl", {5'd0, q_level}, (k == 6) ? 8'd1 : 8'd0);
    end
    coin_half_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("fall_d1", {7'd0, d1}, 8'd0);
    end

    // Glitch shorter than debounce window
    coin_one_raw = 1'b1;
    tick(); tick(); tick();
    coin_one_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("glitch_d2", {7'd0, d2}, 8'd0);
      chk("glitch_lvl", {5'd0, q_level}, 8'd0);
    end

    // Both channels same cycle: half first, then one
    coin_half_raw = 1'b1;
    coin_one_raw  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("both_d1", {7'd0, d1}, (k == 7) ? 8'd1 : 8'd0);
      chk("both_d2", {7'd0, d2}, (k == 8) ? 8'd1 : 8'd0);
      chk("both_lvl", {5'd0, q_level}, (k == 6) ? 8'd2 : (k == 7) ? 8'd1 : 8'd0);
    end
    coin_half_raw = 1'b0;
    coin_one_raw  = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    // Hold while five coins arrive: last is rejected
    hold = 1'b1;
    rej_cnt = 0; pulse_cnt = 0;
    coin(1'b0, 8, 8);
    coin(1'b1, 8, 8);
    coin(1'b1, 8, 8);
    coin(1'b0, 8, 8);
    coin(1'b1, 8, 8);
    chk("hold_lvl", {5'd0, q_level}, 8'd4);
    chk("hold_rej", 8'(rej_cnt), 8'd1);
    chk("hold_pulses", 8'(pulse_cnt), 8'd0);
    hold = 1'b0;
    tick();
    chk("drain0_d1", {7'd0, d1}, 8'd1); chk("drain0_d2", {7'd0, d2}, 8'd0);
    chk("drain0_lvl", {5'd0, q_level}, 8'd3);
    tick();
    chk("drain1_d1", {7'd0, d1}, 8'd0); chk("drain1_d2", {7'd0, d2}, 8'd1);
    chk("drain1_lvl", {5'd0, q_level}, 8'd2);
    tick();
    chk("drain2_d1", {7'd0, d1}, 8'd0); chk("drain2_d2", {7'd0, d2}, 8'd1);
    chk("drain2_lvl", {5'd0, q_level}, 8'd1);
    tick();
    chk("drain3_d1", {7'd0, d1}, 8'd1); chk("drain3_d2", {7'd0, d2}, 8'd0);
    chk("drain3_lvl", {5'd0, q_level}, 8'd0);
    tick();
    chk("drain4_any", {6'd0, d1, d2}, 8'd0);

    // Full queue pops on the same edge a new coin pushes
    hold = 1'b1;
    rej_cnt = 0;
    coin(1'b0, 8, 8);
    coin(1'b1, 8, 8);
    coin(1'b0, 8, 8);
    coin(1'b1, 8, 8);
    chk("full_lvl", {5'd0, q_level}, 8'd4);
    chk("full_rej", 8'(rej_cnt), 8'd0);
    coin_half_raw = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    hold = 1'b0;
    tick();
    chk("swap_d1", {7'd0, d1}, 8'd1);
    chk("swap_lvl", {5'd0, q_level}, 8'd4);
    chk("swap_rej", {7'd0, coin_reject}, 8'd0);
    coin_half_raw = 1'b0;
    tick();
    chk("swap1_d2", {7'd0, d2}, 8'd1);
    chk("swap1_rej", {7'd0, coin_reject}, 8'd0);
    chk("swap1_lvl", {5'd0, q_level}, 8'd3);
    tick(); chk("swap2_d1", {7'd0, d1}, 8'd1);
    tick(); chk("swap3_d2", {7'd0, d2}, 8'd1);
    tick(); chk("swap4_d1", {7'd0, d1}, 8'd1);
    chk("swap4_lvl", {5'd0, q_level}, 8'd0);
    for (int k = 0; k < 10; k++) tick();

    // Reset with three queued and a debounce in flight
    hold = 1'b1;
    coin(1'b0, 8, 8);
    coin(1'b1, 8, 8);
    coin(1'b0, 8, 8);
    chk("pre_rst_lvl", {5'd0, q_level}, 8'd3);
    coin_one_raw = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_lvl", {5'd0, q_level}, 8'd0);
    chk("arst_out", {5'd0, d1, d2, coin_reject}, 8'd0);
    tick();
    rst  = 1'b0;
    hold = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("post_d2", {7'd0, d2}, (k == 7) ? 8'd1 : 8'd0);
      chk("post_d1", {7'd0, d1}, 8'd0);
      chk("post_lvl", {5'd0, q_level}, (k == 6) ? 8'd1 : 8'd0);
    end
    coin_one_raw = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
